// File: rtl/uart_irda_tx.sv
// UART transmit stage with IrDA SIR copy, fed by the byte FIFO.
// Ports: clock/reset, fifo_data/fifo_empty/fifo_rd, irda_mode, tx, irda_tx, busy, tx_done.
module uart_irda_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int IRDA_PULSE   =
    ((3 * CLKS_PER_BIT) / 16 < 1) ? 1 : (3 * CLKS_PER_BIT) / 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic       irda_mode,
  output logic       tx,
  output logic       irda_tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] PULSE_LST = BW'(IRDA_PULSE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          irda_en;

  logic bit_end;
  logic pulse_next;

  assign bit_end = (baud == BAUD_LAST);
  // Next baud value (baud+1) still inside the IrDA pulse window.
  assign pulse_next = irda_en && (baud < PULSE_LST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      irda_en <= 1'b0;
      fifo_rd <= 1'b0;
      tx      <= 1'b1;
      irda_tx <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      irda_tx <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          baud    <= '0;
          bit_idx <= '0;
          if (!fifo_empty) begin
            state <= S_WAIT;
            busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          tx <= 1'b1;
          // Pop only against a non-empty FIFO.
          if (!fifo_empty) begin
            state   <= S_LOAD;
            fifo_rd <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_LOAD: begin
          shift   <= fifo_data;
          irda_en <= irda_mode;
          // First start-bit clock: baud 0, level 0.
          irda_tx <= irda_mode;
          tx      <= 1'b0;
          baud    <= '0;
          bit_idx <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            irda_tx <= irda_en && !shift[0];
            state   <= S_DATA;
          end else begin
            baud    <= baud + 1'b1;
            irda_tx <= pulse_next;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              // shift[1] becomes shift[0] on this edge.
              tx      <= shift[1];
              irda_tx <= irda_en && !shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud    <= baud + 1'b1;
            irda_tx <= pulse_next && !shift[0];
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            if (!fifo_empty) begin
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud <= baud + 1'b1;
            // Registered, so raise it one clock early.
            if (baud == BAUD_PRE) tx_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_irda_tx.sv
// Scoreboard bench for uart_irda_tx.
// Frames are decoded from tx/irda_tx and compared against a bit-level model.
module tb_uart_irda_tx;

  localparam int CPB   = 16;
  localparam int PW    = 3;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd;
  logic       irda_mode = 1'b0;
  logic       tx;
  logic       irda_tx;
  logic       busy;
  logic       tx_done;

  uart_irda_tx #(
    .CLKS_PER_BIT(CPB),
    .IRDA_PULSE  (PW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .irda_mode (irda_mode),
    .tx        (tx),
    .irda_tx   (irda_tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // FIFO model
  logic [7:0] fq[$];
  logic       force_empty = 1'b0;
  int         rd_count = 0;
  int         rd_times[$];
  int         rd_empty_viol = 0;

  always @(posedge clock) begin
    if (fifo_rd === 1'b1) begin
      rd_count++;
      rd_times.push_back(cyc);
      if (fifo_empty) rd_empty_viol++;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    fifo_empty <= force_empty || (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
    cyc++;
  end

  // Scoreboard
  typedef struct {
    logic [7:0] b;
    logic       m;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_byte(input logic [7:0] b, input logic m);
    exp_t e;
    e.b = b;
    e.m = m;
    exp_q.push_back(e);
    fq.push_back(b);
  endtask

  // UART level of frame clock k: start 0, data LSB first, stop 1.
  function automatic logic lvl(input logic [7:0] b, input int k);
    int bi;
    bi = k / CPB;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi-1];
  endfunction

  // Monitor
  logic frame_active = 1'b0;
  int   k = 0;
  exp_t cur;
  int   e_tx, e_ir, e_dn, e_bz, rd_in_frame;
  int   last_end = -100;
  int   last_gap = -1;
  int   idle_viol = 0;
  int   ir_rise = 0;
  logic ir_prev = 1'b0;

  always @(negedge clock) begin
    logic etx, eir;
    if (reset) begin
      frame_active = 1'b0;
      ir_prev = irda_tx;
    end else begin
      if (irda_tx === 1'b1 && ir_prev !== 1'b1) ir_rise++;
      ir_prev = irda_tx;
      if (!frame_active && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got a start bit expected none (cycle %0d)", cyc);
          cur.b = 8'h00;
          cur.m = 1'b0;
        end else begin
          cur = exp_q.pop_front();
        end
        frame_active = 1'b1;
        k = 0;
        e_tx = 0;
        e_ir = 0;
        e_dn = 0;
        e_bz = 0;
        rd_in_frame = 0;
        last_gap = cyc - last_end - 1;
      end
      if (frame_active) begin
        etx = lvl(cur.b, k);
        eir = cur.m && !etx && ((k % CPB) < PW);
        if (tx !== etx) e_tx++;
        if (irda_tx !== eir) e_ir++;
        if (tx_done !== (k == FRAME - 1)) e_dn++;
        if (busy !== 1'b1) e_bz++;
        if (fifo_rd !== 1'b0) rd_in_frame++;
        if (k == FRAME - 1) begin
          check($sformatf("frame_tx_%02h_errs", cur.b), e_tx, 0);
          check($sformatf("frame_irda_%02h_errs", cur.b), e_ir, 0);
          check($sformatf("frame_done_%02h_errs", cur.b), e_dn, 0);
          check($sformatf("frame_busy_%02h_errs", cur.b), e_bz, 0);
          check($sformatf("frame_rd_%02h_errs", cur.b), rd_in_frame, 0);
          frame_active = 1'b0;
          last_end = cyc;
        end
        k++;
      end else begin
        if (tx !== 1'b1 || irda_tx !== 1'b0 || tx_done !== 1'b0)
          idle_viol++;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clock);
    while (n < 4000 && (exp_q.size() != 0 || fq.size() != 0 ||
           frame_active || busy !== 1'b0)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 4000) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy after %0d clocks expected idle", nm, n);
      exp_q.delete();
      fq.delete();
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic wait_frame(input string nm);
    int n;
    n = 0;
    while (n < 500 && !frame_active) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL %s_nostart: got no start bit expected one", nm);
    end
  endtask

  initial begin
    int r0, ir0, viol;
    logic m;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_irda", irda_tx, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", fifo_rd, 0);
    check("rst_done", tx_done, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Single 0x55, UART only
    r0 = rd_count;
    push_byte(8'h55, 1'b0);
    wait_idle("t55");
    check("t55_rd_pulses", rd_count - r0, 1);
    check("t55_busy_after", busy, 0);

    // Back-to-back 0xA3, 0x0F
    r0 = rd_count;
    push_byte(8'hA3, 1'b0);
    push_byte(8'h0F, 1'b0);
    wait_idle("b2b");
    check("b2b_rd_pulses", rd_count - r0, 2);
    check("b2b_rd_spacing",
          rd_times[rd_times.size()-1] - rd_times[rd_times.size()-2], 162);
    check("b2b_idle_gap", last_gap, 2);

    // IrDA 0x00
    irda_mode = 1'b1;
    ir0 = ir_rise;
    push_byte(8'h00, 1'b1);
    wait_idle("irda00");
    irda_mode = 1'b0;
    check("irda00_pulses", ir_rise - ir0, 9);

    // Mid-frame toggles of irda_mode and fifo_empty
    r0 = rd_count;
    ir0 = ir_rise;
    push_byte(8'hFF, 1'b0);
    wait_frame("toggle");
    repeat (20) @(negedge clock);
    for (int i = 0; i < 60; i++) begin
      irda_mode   = 1'($urandom_range(0, 1));
      force_empty = 1'($urandom_range(0, 1));
      if (i == 30) push_byte(8'h3C, 1'b0);
      @(negedge clock);
    end
    irda_mode   = 1'b0;
    force_empty = 1'b0;
    wait_idle("toggle");
    check("toggle_rd_pulses", rd_count - r0, 2);
    check("toggle_rd_spacing",
          rd_times[rd_times.size()-1] - rd_times[rd_times.size()-2], 162);
    check("toggle_irda_pulses", ir_rise - ir0, 0);

    // Random single frames
    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom_range(0, 1));
      irda_mode = m;
      push_byte(8'($urandom), m);
      wait_idle("rand");
    end

    // Random back-to-back burst
    m = 1'($urandom_range(0, 1));
    irda_mode = m;
    r0 = rd_count;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), m);
    wait_idle("burst");
    check("burst_rd_pulses", rd_count - r0, 3);
    check("burst_idle_gap", last_gap, 2);
    irda_mode = 1'b0;

    // Reset mid-frame
    irda_mode = 1'b1;
    push_byte(8'h00, 1'b1);
    wait_frame("midrst");
    repeat (50) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_irda", irda_tx, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    irda_mode = 1'b0;
    r0 = rd_count;
    repeat (100) @(negedge clock);
    check("midrst_rd_after", rd_count - r0, 0);
    check("midrst_busy_after", busy, 0);
    check("midrst_tx_after", tx, 1);

    // fifo_empty held high for 1000 clocks with a byte waiting
    reset = 1'b1;
    force_empty = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    push_byte(8'h5A, 1'b0);
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (fifo_rd !== 1'b0 || tx !== 1'b1 || irda_tx !== 1'b0 ||
          busy !== 1'b0)
        viol++;
    end
    check("hold_empty_viol", viol, 0);
    force_empty = 1'b0;
    wait_idle("release");

    check("idle_line_viol", idle_viol, 0);
    check("rd_while_empty", rd_empty_viol, 0);
    check("leftover_exp", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
